// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory stage.
// Byte access support is enabled by defining DMEM_BYTE_ACCESS_EN.
package dmem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 4;

  localparam logic [3:0] BE_WORD = 4'hF;

  typedef enum logic [0:0] {
    DMEM_IDLE   = 1'b0,
    DMEM_ACCESS = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering for LDRB/STRB: store replication, byte enables and
// zero-extended load lane extraction. Used only with DMEM_BYTE_ACCESS_EN.
module byte_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              st_byte,
  input  logic [1:0]        st_lane,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_byte,
  input  logic [1:0]        ld_lane,
  input  logic [DATA_W-1:0] ld_data,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_result
);

  logic [7:0] ld_lane_s;

  // Store side: one-hot lane enable and the byte copied into every lane.
  always_comb begin
    be    = BE_WORD;
    wdata = st_data;
    if (st_byte) begin
      be    = 4'b0001 << st_lane;
      wdata = DATA_W'({4{st_data[7:0]}});
    end else begin
      be    = BE_WORD;
      wdata = st_data;
    end
  end

  // Load side: select the addressed lane.
  always_comb begin
    ld_lane_s = 8'h00;
    case (ld_lane)
      2'd0:    ld_lane_s = ld_data[7:0];
      2'd1:    ld_lane_s = ld_data[15:8];
      2'd2:    ld_lane_s = ld_data[23:16];
      2'd3:    ld_lane_s = ld_data[31:24];
      default: ld_lane_s = 8'h00;
    endcase
  end

  // Zero-extend the byte for LDRB, pass the word through otherwise.
  always_comb begin
    ld_result = ld_data;
    if (ld_byte) begin
      ld_result = DATA_W'(ld_lane_s);
    end else begin
      ld_result = ld_data;
    end
  end

endmodule

// File: rtl/data_memory_stage.sv
// Memory-access pipeline stage: req/ack data-memory handshake, upstream stall,
// write-back value/register. Define DMEM_BYTE_ACCESS_EN to honour ex_byte.
module data_memory_stage
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_byte,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] dataMemOut,
  output logic [REG_W-1:0]  rd,
  output logic              wb_valid
);

  dmem_state_e       state_r, state_s;
  logic              mem_op_s;
  logic [REG_W-1:0]  rd_lat_r, rd_lat_s;
  logic              is_byte_r, is_byte_s;
  logic [1:0]        lane_r, lane_s;

  logic              req_s, we_s, wb_valid_s;
  logic [DATA_W-1:0] addr_s, wdata_nx_s, dout_s;
  logic [3:0]        be_nx_s;
  logic [REG_W-1:0]  rd_s;

  logic [3:0]        be_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] load_data_s;

  assign mem_op_s = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef DMEM_BYTE_ACCESS_EN
  byte_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_byte   (ex_byte),
    .st_lane   (ex_addr[1:0]),
    .st_data   (ex_store_data),
    .ld_byte   (is_byte_r),
    .ld_lane   (lane_r),
    .ld_data   (mem_rdata),
    .be        (be_s),
    .wdata     (wdata_s),
    .ld_result (load_data_s)
  );
`else
  logic unused_byte_s;
  assign unused_byte_s = ^{is_byte_r, lane_r};
  assign be_s          = BE_WORD;
  assign wdata_s       = ex_store_data;
  assign load_data_s   = mem_rdata;
`endif

  // Upstream must hold while a memory op waits to issue or is unacknowledged.
  always_comb begin
    stall = 1'b0;
    case (state_r)
      DMEM_IDLE:   stall = mem_op_s;
      DMEM_ACCESS: stall = ~mem_ack;
      default:     stall = 1'b0;
    endcase
  end

  // Next-state and next-output logic; mem_* hold unless a new access issues.
  always_comb begin
    state_s    = state_r;
    req_s      = mem_req;
    we_s       = mem_we;
    addr_s     = mem_addr;
    wdata_nx_s = mem_wdata;
    be_nx_s    = mem_be;
    dout_s     = dataMemOut;
    rd_s       = rd;
    wb_valid_s = 1'b0;
    rd_lat_s   = rd_lat_r;
    is_byte_s  = is_byte_r;
    lane_s     = lane_r;
    case (state_r)
      DMEM_IDLE: begin
        if (mem_op_s) begin
          state_s    = DMEM_ACCESS;
          req_s      = 1'b1;
          we_s       = ex_mem_write;
          addr_s     = {ex_addr[DATA_W-1:2], 2'b00};
          wdata_nx_s = wdata_s;
          be_nx_s    = be_s;
          rd_lat_s   = ex_rd;
          is_byte_s  = ex_byte;
          lane_s     = ex_addr[1:0];
        end else if (ex_valid) begin
          dout_s     = ex_addr;
          rd_s       = ex_rd;
          wb_valid_s = 1'b1;
        end else begin
          wb_valid_s = 1'b0;
        end
      end
      DMEM_ACCESS: begin
        if (mem_ack) begin
          state_s = DMEM_IDLE;
          req_s   = 1'b0;
          if (!mem_we) begin
            dout_s     = load_data_s;
            rd_s       = rd_lat_r;
            wb_valid_s = 1'b1;
          end else begin
            wb_valid_s = 1'b0;
          end
        end else begin
          wb_valid_s = 1'b0;
        end
      end
      default: begin
        state_s = DMEM_IDLE;
        req_s   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any outstanding access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= DMEM_IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= 4'h0;
      dataMemOut <= '0;
      rd         <= '0;
      wb_valid   <= 1'b0;
      rd_lat_r   <= '0;
      is_byte_r  <= 1'b0;
      lane_r     <= 2'd0;
    end else begin
      state_r    <= state_s;
      mem_req    <= req_s;
      mem_we     <= we_s;
      mem_addr   <= addr_s;
      mem_wdata  <= wdata_nx_s;
      mem_be     <= be_nx_s;
      dataMemOut <= dout_s;
      rd         <= rd_s;
      wb_valid   <= wb_valid_s;
      rd_lat_r   <= rd_lat_s;
      is_byte_r  <= is_byte_s;
      lane_r     <= lane_s;
    end
  end

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed, table-driven bench for data_memory_stage (word mode by default,
// byte-lane expectations switch with DMEM_BYTE_ACCESS_EN).
module tb_data_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_byte;
  logic [31:0] ex_addr, ex_store_data;
  logic [3:0]  ex_rd;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] dataMemOut;
  logic [3:0]  rd;
  logic        wb_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory_stage #(.DATA_W(32), .REG_W(4)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_byte(ex_byte), .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dataMemOut(dataMemOut), .rd(rd), .wb_valid(wb_valid)
  );

  typedef struct {
    logic        v, r, w, b;
    logic [31:0] addr, sdata;
    logic [3:0]  exrd;
    logic [31:0] rdata;
    logic        ack;
    logic        e_stall, e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic [31:0] e_dout;
    logic [3:0]  e_rd;
    logic        e_wb;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(
    input logic v, r, w, b, input logic [31:0] addr, sdata, input logic [3:0] exrd,
    input logic [31:0] rdata, input logic ack,
    input logic e_stall, e_req, e_we, input logic [31:0] e_addr, e_wdata,
    input logic [3:0] e_be, input logic [31:0] e_dout, input logic [3:0] e_rd,
    input logic e_wb);
    vec_t t;
    t.v = v; t.r = r; t.w = w; t.b = b; t.addr = addr; t.sdata = sdata;
    t.exrd = exrd; t.rdata = rdata; t.ack = ack;
    t.e_stall = e_stall; t.e_req = e_req; t.e_we = e_we; t.e_addr = e_addr;
    t.e_wdata = e_wdata; t.e_be = e_be; t.e_dout = e_dout; t.e_rd = e_rd; t.e_wb = e_wb;
    return t;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic v, r, w, b, input logic [31:0] addr, sdata,
                       input logic [3:0] exrd, input logic [31:0] rdata, input logic ack);
    ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_byte = b;
    ex_addr = addr; ex_store_data = sdata; ex_rd = exrd; mem_rdata = rdata; mem_ack = ack;
  endtask

  logic [3:0]  be_b1, be_b2;
  logic [31:0] dout_b, wd_b;
  int          req_rises;
  logic        prev_req;

  initial begin
`ifdef DMEM_BYTE_ACCESS_EN
    be_b1 = 4'b0100; be_b2 = 4'b1000; dout_b = 32'h0000_0022; wd_b = 32'hABAB_ABAB;
`else
    be_b1 = 4'hF;    be_b2 = 4'hF;    dout_b = 32'h1122_3344; wd_b = 32'h0000_00AB;
`endif
    //          v  r  w  b  addr          sdata         rd     rdata         ack  stall req we  addr          wdata         be     dout          rd     wb
    vt[0]  = mk(1'b1,1'b0,1'b0,1'b0,32'h1234,32'h0,4'd3,32'h0,1'b0, 1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,32'h1234,4'd3,1'b1);
    vt[1]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'd0,32'h0,1'b0,    1'b0,1'b0,1'b0,32'h0,32'h0,4'h0,32'h1234,4'd3,1'b0);
    vt[2]  = mk(1'b1,1'b1,1'b0,1'b0,32'h104,32'h0,4'd5,32'h0,1'b0,  1'b1,1'b1,1'b0,32'h104,32'h0,4'hF,32'h1234,4'd3,1'b0);
    vt[3]  = vt[2];
    vt[4]  = vt[2];
    vt[5]  = vt[2];
    vt[6]  = mk(1'b1,1'b1,1'b0,1'b0,32'h104,32'h0,4'd5,32'hDEAD_BEEF,1'b1, 1'b0,1'b0,1'b0,32'h104,32'h0,4'hF,32'hDEAD_BEEF,4'd5,1'b1);
    vt[7]  = mk(1'b1,1'b0,1'b1,1'b0,32'h200,32'hCAFE_F00D,4'd0,32'h0,1'b0, 1'b1,1'b1,1'b1,32'h200,32'hCAFE_F00D,4'hF,32'hDEAD_BEEF,4'd5,1'b0);
    vt[8]  = mk(1'b1,1'b0,1'b1,1'b0,32'h200,32'hCAFE_F00D,4'd0,32'h0,1'b1, 1'b0,1'b0,1'b1,32'h200,32'hCAFE_F00D,4'hF,32'hDEAD_BEEF,4'd5,1'b0);
    vt[9]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'd0,32'hFFFF_FFFF,1'b1, 1'b0,1'b0,1'b1,32'h200,32'hCAFE_F00D,4'hF,32'hDEAD_BEEF,4'd5,1'b0);
    vt[10] = mk(1'b1,1'b1,1'b0,1'b0,32'h10,32'h0,4'd7,32'h0,1'b0,   1'b1,1'b1,1'b0,32'h10,32'h0,4'hF,32'hDEAD_BEEF,4'd5,1'b0);
    vt[11] = mk(1'b1,1'b1,1'b0,1'b0,32'h10,32'h0,4'd7,32'h55,1'b1,  1'b0,1'b0,1'b0,32'h10,32'h0,4'hF,32'h55,4'd7,1'b1);
    vt[12] = mk(1'b1,1'b0,1'b1,1'b0,32'h20,32'h99,4'd0,32'h0,1'b0,  1'b1,1'b1,1'b1,32'h20,32'h99,4'hF,32'h55,4'd7,1'b0);
    vt[13] = mk(1'b1,1'b0,1'b1,1'b0,32'h20,32'h99,4'd0,32'h0,1'b1,  1'b0,1'b0,1'b1,32'h20,32'h99,4'hF,32'h55,4'd7,1'b0);
    vt[14] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'd0,32'h0,1'b0,    1'b0,1'b0,1'b1,32'h20,32'h99,4'hF,32'h55,4'd7,1'b0);
    vt[15] = mk(1'b1,1'b1,1'b0,1'b1,32'h102,32'h0,4'd2,32'h0,1'b0,  1'b1,1'b1,1'b0,32'h100,32'h0,be_b1,32'h55,4'd7,1'b0);
    vt[16] = mk(1'b1,1'b1,1'b0,1'b1,32'h102,32'h0,4'd2,32'h1122_3344,1'b1, 1'b0,1'b0,1'b0,32'h100,32'h0,be_b1,dout_b,4'd2,1'b1);
    vt[17] = mk(1'b1,1'b0,1'b1,1'b1,32'h103,32'hAB,4'd0,32'h0,1'b0, 1'b1,1'b1,1'b1,32'h100,wd_b,be_b2,dout_b,4'd2,1'b0);
    vt[18] = mk(1'b1,1'b0,1'b1,1'b1,32'h103,32'hAB,4'd0,32'h0,1'b1, 1'b0,1'b0,1'b1,32'h100,wd_b,be_b2,dout_b,4'd2,1'b0);
    vt[19] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'd0,32'h0,1'b0,    1'b0,1'b0,1'b1,32'h100,wd_b,be_b2,dout_b,4'd2,1'b0);

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", -1, {31'd0, mem_req}, 32'd0);
    check("rst_dout", -1, dataMemOut, 32'd0);
    check("rst_misc", -1, {mem_addr[15:0], mem_be, rd, 2'd0, wb_valid, mem_we, stall}, 32'd0);
    check("rst_wdata", -1, mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    req_rises = 0;
    prev_req  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vt[i].v, vt[i].r, vt[i].w, vt[i].b, vt[i].addr, vt[i].sdata, vt[i].exrd, vt[i].rdata, vt[i].ack);
      #1;
      check("stall", i, {31'd0, stall}, {31'd0, vt[i].e_stall});
      @(posedge clk);
      #1;
      check("mem_req", i, {31'd0, mem_req}, {31'd0, vt[i].e_req});
      check("mem_we", i, {31'd0, mem_we}, {31'd0, vt[i].e_we});
      check("mem_addr", i, mem_addr, vt[i].e_addr);
      check("mem_wdata", i, mem_wdata, vt[i].e_wdata);
      check("mem_be", i, {28'd0, mem_be}, {28'd0, vt[i].e_be});
      check("dataMemOut", i, dataMemOut, vt[i].e_dout);
      check("rd", i, {28'd0, rd}, {28'd0, vt[i].e_rd});
      check("wb_valid", i, {31'd0, wb_valid}, {31'd0, vt[i].e_wb});
      if (mem_req && !prev_req) req_rises++;
      prev_req = mem_req;
    end
    check("req_issue_count", 20, req_rises, 32'd6);

    // Reset while an access is outstanding, then a clean load.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 4'd9, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_req", 30, {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_req", 31, {31'd0, mem_req}, 32'd0);
    check("midrst_addr", 31, mem_addr, 32'd0);
    check("midrst_dout", 31, dataMemOut, 32'd0);
    check("midrst_misc", 31, {mem_be, rd, wb_valid, mem_we, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 4'd4, 32'h0, 1'b0);
    #1;
    check("post_stall", 32, {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    check("post_req", 32, {31'd0, mem_req}, 32'd1);
    check("post_addr", 32, mem_addr, 32'h304);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 4'd4, 32'h0BAD_F00D, 1'b1);
    #1;
    check("post_ack_stall", 33, {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    check("post_dout", 33, dataMemOut, 32'h0BAD_F00D);
    check("post_rd", 33, {28'd0, rd}, 32'd4);
    check("post_wb", 33, {31'd0, wb_valid}, 32'd1);
    check("post_req_drop", 33, {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 32'h0, 1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_stage.md
# data_memory_stage

Memory-access stage of the pipelined ARM core: sits between the EX/MEM pipeline register and the MEM/WB data-memory register. Drives the data memory on a req/ack handshake, stalls the upstream pipeline while an access is outstanding, and produces the write-back value (`dataMemOut`) and destination register (`rd`). Non-memory instructions pass their ALU result through with one cycle of latency.

## Interface
Parameters:
- `DATA_W`, 32: data and address width
- `REG_W`, 4: register-index width (r0–r15)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `ex_valid` in 1: EX/MEM holds a valid instruction
- `ex_mem_read` in 1: LDR/LDRB
- `ex_mem_write` in 1: STR/STRB
- `ex_byte` in 1: byte access (LDRB/STRB)
- `ex_addr` in DATA_W: ALU result (memory address, or the result itself for non-memory ops)
- `ex_store_data` in DATA_W: store data
- `ex_rd` in REG_W: destination register
- `stall` out 1: hold EX/MEM and everything upstream
- `mem_req` out 1: access request
- `mem_we` out 1: 1 = write
- `mem_addr` out DATA_W: word-aligned address
- `mem_wdata` out DATA_W: write data
- `mem_be` out 4: byte enables
- `mem_rdata` in DATA_W: read data, valid with `mem_ack`
- `mem_ack` in 1: access complete
- `dataMemOut` out DATA_W: write-back value, to MEM/WB
- `rd` out REG_W: write-back register, to MEM/WB
- `wb_valid` out 1: `dataMemOut`/`rd` must be written to the register file

## Operation
- FSM has two states: IDLE and ACCESS.
- Memory op means `ex_valid & (ex_mem_read | ex_mem_write)`. If both read and write are high, the access is a write.
- **IDLE, memory op present:**
  - Latch address, store data, `ex_rd`, type and byte flag.
  - Register `mem_req`=1, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata`; go to ACCESS.
  - Outputs next cycle: `wb_valid`=0 (bubble).
- **IDLE, valid non-memory op:** next cycle `dataMemOut`=`ex_addr`, `rd`=`ex_rd`, `wb_valid`=1.
- **IDLE, `ex_valid`=0:** next cycle `wb_valid`=0. `dataMemOut`/`rd` hold their previous values.
- **ACCESS:**
  - `mem_req` and all `mem_*` outputs hold stable until `mem_ack`.
  - On ack: return to IDLE and drop `mem_req` next cycle.
  - Load: register extracted data into `dataMemOut`, latched rd into `rd`, `wb_valid`=1.
  - Store: `wb_valid`=0.
- `stall` is combinational: (IDLE & memory op) | (ACCESS & !`mem_ack`). It drops in the ack cycle so the upstream pipeline advances on that edge. No instruction is issued twice.
- `mem_ack` while in IDLE is ignored.
- Address handling:
  - `mem_addr` = {addr[DATA_W-1:2], 2'b00}.
  - Word access: `mem_be`=4'hF. addr[1:0] is ignored; unaligned addresses are aligned down.

## Timing
- Reset (async assert, sync release): state IDLE; `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `dataMemOut`, `rd`, `wb_valid` all 0. `stall` follows its equation, so it is 0 while `ex_valid`=0.
- Reset mid-ACCESS: `mem_req` falls immediately and the access is abandoned. The memory must tolerate a dropped request.
- Non-memory op: 1-cycle latency, zero stall.
- Load/store with ack in the first ACCESS cycle: op presented cycle 0 (`stall`=1), `mem_req` cycle 1, ack cycle 1, `wb_valid` cycle 2. That is 2-cycle latency and 1 stall cycle.
- Each extra wait cycle before ack adds one stall cycle and one cycle of latency.

## Configuration
- Macro `DMEM_BYTE_ACCESS_EN`.
- **Defined:** `ex_byte` is honoured.
  - `mem_be` = 4'b0001 << addr[1:0].
  - `mem_wdata` = store byte [7:0] replicated into all four lanes.
  - Load result = byte lane addr[1:0] of `mem_rdata`, zero-extended to DATA_W.
- **Undefined:** `ex_byte` is ignored and every access is a word access.

## Structure
- Package `dmem_pkg` contains:
  - FSM state enum (`DMEM_IDLE`, `DMEM_ACCESS`)
  - `DATA_W`/`REG_W` defaults
  - `BE_WORD`=4'hF
- Sub-module `byte_lane_align`: combinational store replication, byte-enable generation and load lane extraction. It is instantiated only under `DMEM_BYTE_ACCESS_EN`.

## Test plan
- Non-memory op, `ex_addr`=32'h0000_1234, `ex_rd`=3 → next cycle `dataMemOut`=32'h1234, `rd`=3, `wb_valid`=1, `stall` never high.
- LDR addr 32'h0000_0104, ack after 3 wait cycles with `mem_rdata`=32'hDEAD_BEEF, `ex_rd`=5 → `stall` high 4 cycles, `mem_addr`=32'h104 with `mem_be`=4'hF held stable, then `dataMemOut`=32'hDEAD_BEEF, `rd`=5, `wb_valid`=1.
- STR addr 32'h0000_0200, data 32'hCAFE_F00D, immediate ack → `mem_we`=1, `mem_wdata`=32'hCAFE_F00D, 1 stall cycle, `wb_valid`=0.
- With `DMEM_BYTE_ACCESS_EN`:
  - LDRB addr 32'h0000_0102, `mem_rdata`=32'h1122_3344 → `mem_be`=4'b0100, `dataMemOut`=32'h0000_0022.
  - STRB data 32'h0000_00AB addr 32'h0000_0103 → `mem_wdata`=32'hABAB_ABAB, `mem_be`=4'b1000.
- Assert `reset` low while in ACCESS → `mem_req` is 0 immediately; all outputs 0; after release, a new LDR completes normally.
- Back-to-back LDR then STR, each with immediate ack → exactly one `mem_req` per instruction, no re-issue, total 4 cycles to drain.
